sys_bus_arbiter: RTL

// - Two-master, one-slave arbiter for the system bus (addr/wdata/sel/wen/ren -> rdata/err/ack).
// - Lets the PS-AXI bridge (m0) and a second master, e.g. a test sequencer (m1), share one decoded slave bus.
// - Captures single-cycle master strobes and round-robins between pending requests.
// - Keeps one transaction outstanding at a time.

---
 rtl/sys_bus_arb_pkg.sv | 21 ++
 rtl/sys_bus_arbiter_if.sv | 28 ++
 rtl/sys_bus_arb_rr2.sv | 28 ++
 rtl/sys_bus_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sys_bus_arb_pkg.sv
// Shared types for the two-master system bus arbiter.
// Counter sizing helper is only used when SYS_BUS_ARB_TIMEOUT_EN is defined.
package sys_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef logic mst_t;

  localparam int CNT_MIN_W = 8;

  function automatic int cnt_width(input int cyc);
    int w;
    w = $clog2(cyc + 1);
    return (w < CNT_MIN_W) ? CNT_MIN_W : w;
  endfunction

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// Strobe bus bundle: master drives request, slave returns rdata/err/ack.
// Used for both master ports and the shared slave port of the arbiter.
interface sys_bus_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int SW = DW >> 3
);

  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] sel;
  logic          wen;
  logic          ren;
  logic [DW-1:0] rdata;
  logic          err;
  logic          ack;

  modport master (
    output addr, wdata, sel, wen, ren,
    input  rdata, err, ack
  );

  modport slave (
    input  addr, wdata, sel, wen, ren,
    output rdata, err, ack
  );

endinterface

// File: rtl/sys_bus_arb_rr2.sv
// Two-way round-robin grant; pointer moves to the master
// opposite the one whose transaction just completed.
module sys_bus_arb_rr2
  import sys_bus_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  input  mst_t       last,
  output logic       any,
  output mst_t       gnt
);

  mst_t ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (done) begin
      ptr <= ~last;
    end
  end

  assign any = |req;
  assign gnt = (&req) ? ptr : req[1];

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-master, one-slave strobe bus arbiter, one transaction in flight.
// Define SYS_BUS_ARB_TIMEOUT_EN to bound the slave wait by TIMEOUT_CYC.
module sys_bus_arbiter
  import sys_bus_arb_pkg::*;
#(
  parameter int AXI_DW = 32,
  parameter int AXI_AW = 32,
  parameter int AXI_SW = AXI_DW >> 3
`ifdef SYS_BUS_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input logic               sys_clk_i,
  input logic               sys_rst_i,
  sys_bus_arbiter_if.slave  m0,
  sys_bus_arbiter_if.slave  m1,
  sys_bus_arbiter_if.master sys
);

  state_t            state;
  mst_t              cur;
  logic [1:0]        pend;
  logic [AXI_AW-1:0] l_addr  [2];
  logic [AXI_DW-1:0] l_wdata [2];
  logic [AXI_SW-1:0] l_sel   [2];
  logic [1:0]        l_we;
  logic [1:0]        strb;
  logic [1:0]        owned;
  logic [1:0]        take;
  logic              any;
  mst_t              gnt;
  logic              to_hit;
  logic              done;
  logic [AXI_DW-1:0] rsp_data;
  logic              rsp_err;

  assign strb     = {m1.wen | m1.ren, m0.wen | m0.ren};
  assign owned[0] = (state != IDLE) && !cur;
  assign owned[1] = (state != IDLE) && cur;
  assign take     = strb & ~pend & ~owned;

`ifdef SYS_BUS_ARB_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i || state != WAIT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // a real ack in the expiry cycle takes priority
  assign to_hit = !sys.ack && (cnt == CNT_LAST);
`else
  assign to_hit = 1'b0;
`endif

  assign done     = (state == WAIT) && (sys.ack || to_hit);
  assign rsp_data = sys.ack ? sys.rdata : '0;
  assign rsp_err  = sys.ack ? sys.err : 1'b1;

  sys_bus_arb_rr2 u_rr2 (
    .clk  (sys_clk_i),
    .rst  (sys_rst_i),
    .req  (pend),
    .done (done),
    .last (cur),
    .any  (any),
    .gnt  (gnt)
  );

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state     <= IDLE;
      cur       <= 1'b0;
      pend      <= '0;
      l_we      <= '0;
      sys.addr  <= '0;
      sys.wdata <= '0;
      sys.sel   <= '0;
      sys.wen   <= 1'b0;
      sys.ren   <= 1'b0;
      m0.rdata  <= '0;
      m0.err    <= 1'b0;
      m0.ack    <= 1'b0;
      m1.rdata  <= '0;
      m1.err    <= 1'b0;
      m1.ack    <= 1'b0;
    end else begin
      sys.wen <= 1'b0;
      sys.ren <= 1'b0;
      m0.ack  <= 1'b0;
      m1.ack  <= 1'b0;

      if (take[0]) begin
        pend[0]    <= 1'b1;
        l_addr[0]  <= m0.addr;
        l_wdata[0] <= m0.wdata;
        l_sel[0]   <= m0.sel;
        l_we[0]    <= m0.wen;
      end
      if (take[1]) begin
        pend[1]    <= 1'b1;
        l_addr[1]  <= m1.addr;
        l_wdata[1] <= m1.wdata;
        l_sel[1]   <= m1.sel;
        l_we[1]    <= m1.wen;
      end

      unique case (state)
        IDLE: begin
          if (any) begin
            cur       <= gnt;
            pend[gnt] <= 1'b0;
            sys.addr  <= l_addr[gnt];
            sys.wdata <= l_wdata[gnt];
            sys.sel   <= l_sel[gnt];
            sys.wen   <= l_we[gnt];
            sys.ren   <= !l_we[gnt];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done) begin
            if (cur) begin
              m1.ack   <= 1'b1;
              m1.rdata <= rsp_data;
              m1.err   <= rsp_err;
            end else begin
              m0.ack   <= 1'b1;
              m0.rdata <= rsp_data;
              m0.err   <= rsp_err;
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
